mru_push_scheduler: RTL and testbench

- Front-end controller for the MRU stack datapath.
- Synchronizes and debounces the four raw buttons b1..b4 and converts each press into one push request.
- Arbitrates simultaneous or queued requests round-robin and hands them to the stack one at a time over a valid/ready handshake.
- Sits between the board buttons and the MRU stack. `tick` comes from the existing timer block.

---
 rtl/mru_push_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_mru_push_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mru_push_scheduler.sv
// mru_push_scheduler: button front end for the MRU stack.
// Sync, debounce, edge-to-request, round-robin push handshake.
module mru_push_scheduler #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       push_ready,
  output logic       push_valid,
  output logic [2:0] push_id,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_e;

  logic [3:0]       raw;
  logic [3:0]       s1_q;
  logic [3:0]       s2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] rise;
  logic [3:0] clr;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] sel_q;
  logic [1:0] sel_d;
  logic [1:0] last_q;
  logic [1:0] last_d;
  logic       valid_q;
  logic       valid_d;
  logic [2:0] id_q;
  logic [2:0] id_d;

  logic       found;
  logic [1:0] pick;
  logic       hs;

  assign raw = {b4, b3, b2, b1};

  // Two-flop synchronizer, runs every clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: stable level flips after enough differing ticks
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + CNT_W'(1)
                     == CNT_W'(DEBOUNCE_TICKS)) begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and previous stable level for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise      = stable_q & ~prev_q;
  assign pending_d = (pending_q & ~clr) | rise;
  assign hs        = valid_q & push_ready;

  // Round-robin pick: first pending bit after last, wrapping
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= 2'd3;
      valid_q   <= 1'b0;
      id_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      pending_q <= pending_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = OFFER;
      OFFER:   if (hs) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next outputs, grant bookkeeping
  always_comb begin
    valid_d = 1'b0;
    id_d    = '0;
    sel_d   = sel_q;
    last_d  = last_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          valid_d = 1'b1;
          id_d    = {1'b0, pick} + 3'd1;
        end
      end
      OFFER: begin
        if (hs) begin
          clr[sel_q] = 1'b1;
          last_d     = sel_q;
        end else begin
          valid_d = 1'b1;
          id_d    = id_q;
        end
      end
      default: ;
    endcase
  end

  assign push_valid = valid_q;
  assign push_id    = id_q;
  assign pending    = pending_q;
  assign busy       = (pending_q != 4'd0) || (state_q != IDLE);

endmodule

// File: tb/tb_mru_push_scheduler.sv
// tb_mru_push_scheduler: scoreboard bench for mru_push_scheduler.
// Expected push ids are queued at press time, popped on handshake.
module tb_mru_push_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       b1, b2, b3, b4;
  logic       push_ready;
  logic       push_valid;
  logic [2:0] push_id;
  logic [3:0] pending;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int sb[$];
  int hs_cyc[$];
  int model_last = 3;

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [2:0] pid = '0;

  mru_push_scheduler #(
    .DEBOUNCE_TICKS(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .b1(b1),
    .b2(b2),
    .b3(b3),
    .b4(b4),
    .push_ready(push_ready),
    .push_valid(push_valid),
    .push_id(push_id),
    .pending(pending),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      seen = push_valid;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: got no push_valid expected one within %0d clks",
               nm, maxc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    for (int k = 0; k < maxc && sb.size() != 0; k++) step(1);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d pushes outstanding expected 0",
               nm, sb.size());
    end
  endtask

  // Monitor: protocol checks and scoreboard pop on handshake
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      pv  = 1'b0;
      pr  = 1'b0;
      pid = '0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(push_valid), 1);
        chk("hold_id", int'(push_id), int'(pid));
      end
      if (pv && pr) chk("gap_after_push", int'(push_valid), 0);
      if (push_valid) valid_cnt++;
      if (push_valid && push_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_push: got id %0d expected none",
                   push_id);
        end else begin
          e = sb.pop_front();
          chk("push_id", int'(push_id), e);
        end
      end
      pv  = push_valid;
      pr  = push_ready;
      pid = push_id;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int         vc;
    bit         ok;
    logic [3:0] sub;
    int         idx;
    int         nl;

    rst        = 1'b0;
    tick       = 1'b1;
    {b4, b3, b2, b1} = 4'b0000;
    push_ready = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_valid", int'(push_valid), 0);
    chk("rst_id", int'(push_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(3);

    // single press: 2 sync + 3 ticks, pending +1, valid +1
    sb.push_back(2);
    b2 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_pending", int'(pending), 2);
    chk("lat_valid_early", int'(push_valid), 0);
    @(negedge clk);
    chk("lat_valid", int'(push_valid), 1);
    chk("lat_id", int'(push_id), 2);
    @(negedge clk);
    chk("gap_valid", int'(push_valid), 0);
    chk("gap_pending", int'(pending), 0);
    chk("gap_busy", int'(busy), 1);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    step(20);
    chk("held_pending", int'(pending), 0);
    chk("held_sb", sb.size(), 0);
    b2 = 1'b0;
    step(12);
    model_last = 1;

    // bounce rejection
    vc = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      b3 = (i % 2 == 0);
      step(1);
    end
    b3 = 1'b0;
    step(15);
    chk("bounce_valid", valid_cnt, vc);
    chk("bounce_pending", int'(pending), 0);

    // simultaneous press after reset
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    hs_cyc.delete();
    sb.push_back(1);
    sb.push_back(2);
    sb.push_back(3);
    sb.push_back(4);
    {b4, b3, b2, b1} = 4'b1111;
    wait_drain(100, "rr_drain");
    step(2);
    chk("rr_count", hs_cyc.size(), 4);
    if (hs_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    {b4, b3, b2, b1} = 4'b0000;
    step(12);
    sb.push_back(1);
    sb.push_back(4);
    {b4, b1} = 2'b11;
    wait_drain(100, "rr14_drain");
    {b4, b1} = 2'b00;
    step(12);

    // backpressure
    push_ready = 1'b0;
    sb.push_back(4);
    b4 = 1'b1;
    wait_valid(30, "bp_valid");
    chk("bp_id", int'(push_id), 4);
    b1 = 1'b1;
    sb.push_back(1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(push_valid && push_id == 3'd4)) ok = 1'b0;
    end
    chk("bp_steady", int'(ok), 1);
    @(posedge clk);
    #1 push_ready = 1'b1;
    wait_drain(50, "bp_drain");
    {b4, b1} = 2'b00;
    step(12);

    // merge while stalled
    push_ready = 1'b0;
    sb.push_back(2);
    b2 = 1'b1;
    wait_valid(30, "merge_valid");
    b2 = 1'b0;
    step(12);
    b2 = 1'b1;
    step(12);
    chk("merge_pending", int'(pending), 2);
    chk("merge_id", int'(push_id), 2);
    push_ready = 1'b1;
    wait_drain(20, "merge_drain");
    step(20);
    b2 = 1'b0;
    step(12);

    // edge lands on the handshake cycle
    push_ready = 1'b0;
    sb.push_back(2);
    b2 = 1'b1;
    wait_valid(30, "coll_valid");
    b2 = 1'b0;
    step(12);
    sb.push_back(2);
    b2 = 1'b1;
    step(5);
    push_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("coll_pending", int'(pending), 2);
    chk("coll_gap", int'(push_valid), 0);
    @(posedge clk);
    #1;
    wait_drain(20, "coll_drain");
    b2 = 1'b0;
    step(12);
    model_last = 1;

    // randomized rounds against round-robin model
    for (int r = 0; r < 20; r++) begin
      sub = 4'($urandom_range(1, 15));
      nl  = model_last;
      for (int k = 1; k <= 4; k++) begin
        idx = (model_last + k) % 4;
        if (sub[idx]) begin
          sb.push_back(idx + 1);
          nl = idx;
        end
      end
      model_last = nl;
      {b4, b3, b2, b1} = sub;
      for (int k = 0; k < 3000 && sb.size() != 0; k++) begin
        tick       = 1'($urandom_range(0, 1));
        push_ready = 1'($urandom_range(0, 1));
        step(1);
      end
      if (sb.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL rand_drain: got %0d outstanding expected 0",
                 sb.size());
        sb.delete();
      end
      tick       = 1'b1;
      push_ready = 1'b1;
      {b4, b3, b2, b1} = 4'b0000;
      step(12);
      chk("rand_idle", int'(busy), 0);
    end

    // async reset while offering
    push_ready = 1'b0;
    {b4, b2, b1} = 3'b111;
    wait_valid(30, "rst_mid_valid");
    @(negedge clk);
    chk("rst_mid_pending", int'(pending), 11);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", int'(push_valid), 0);
    chk("rst_mid_id", int'(push_id), 0);
    chk("rst_mid_pend0", int'(pending), 0);
    chk("rst_mid_busy", int'(busy), 0);
    sb.delete();
    vc = valid_cnt;
    {b4, b3, b2, b1} = 4'b0000;
    push_ready = 1'b1;
    step(3);
    rst = 1'b1;
    step(30);
    chk("post_rst_nopush", valid_cnt, vc);
    chk("post_rst_pending", int'(pending), 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
